// File: rtl/flash_rr_arbiter_if.sv
// Host, read-client and flash-controller signals around flash_rr_arbiter.
// The arbiter takes the slave side; whatever drives the ports takes master.
interface flash_rr_arbiter_if #(
    parameter int NUM_RD = 3,
    parameter int ADDR_W = 22,
    parameter int DATA_W = 8,
    parameter int CMD_W  = 3
);
    logic [ADDR_W-1:0]        iHS_ADDR;
    logic [DATA_W-1:0]        iHS_DATA;
    logic [CMD_W-1:0]         iHS_CMD;
    logic                     iHS_Start;
    logic [DATA_W-1:0]        oHS_DATA;
    logic                     oHS_Ready;
    logic [NUM_RD-1:0]        iRD_REQ;
    logic [NUM_RD*ADDR_W-1:0] iRD_ADDR;
    logic [NUM_RD*DATA_W-1:0] oRD_DATA;
    logic [NUM_RD-1:0]        oRD_VALID;
    logic [NUM_RD-1:0]        oRD_ERR;
    logic [NUM_RD:0]          oGRANT;
    logic [ADDR_W-1:0]        oFL_ADDR;
    logic [DATA_W-1:0]        oFL_DATA;
    logic [CMD_W-1:0]         oFL_CMD;
    logic                     oFL_Start;
    logic [DATA_W-1:0]        iFL_DATA;
    logic                     iFL_Ready;

    modport slave (
        input  iHS_ADDR, iHS_DATA, iHS_CMD, iHS_Start,
        input  iRD_REQ, iRD_ADDR, iFL_DATA, iFL_Ready,
        output oHS_DATA, oHS_Ready, oRD_DATA, oRD_VALID,
        output oRD_ERR, oGRANT, oFL_ADDR, oFL_DATA,
        output oFL_CMD, oFL_Start
    );

    modport master (
        output iHS_ADDR, iHS_DATA, iHS_CMD, iHS_Start,
        output iRD_REQ, iRD_ADDR, iFL_DATA, iFL_Ready,
        input  oHS_DATA, oHS_Ready, oRD_DATA, oRD_VALID,
        input  oRD_ERR, oGRANT, oFL_ADDR, oFL_DATA,
        input  oFL_CMD, oFL_Start
    );
endinterface

// File: rtl/flash_rr_arbiter.sv
// Shares one flash controller between a full-command host port and
// NUM_RD read-only clients using round-robin arbitration.
module flash_rr_arbiter #(
    parameter int NUM_RD    = 3,
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 8,
    parameter int CMD_W     = 3,
    parameter int RD_CMD    = 0,
    parameter int HOST_PRIO = 1,
    parameter int GAP_CYC   = 2,
    parameter int TIMEOUT   = 4095
) (
    input logic               iCLK,
    input logic               iRST,
    flash_rr_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_HOST, S_GAP
    } state_e;

    localparam int NS = (HOST_PRIO != 0) ? NUM_RD : NUM_RD + 1;
    localparam int PW = (NS > 1) ? $clog2(NS) : 1;
    localparam int OW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int IW = $clog2(NUM_RD + 1);
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam int GW = $clog2(GAP_CYC + 1);

    state_e            state_q, state_d;
    logic              start_q, start_d;
    logic [NUM_RD:0]   grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q [NUM_RD];
    logic [DATA_W-1:0] data_d [NUM_RD];
    logic [NUM_RD-1:0] valid_q, valid_d;
    logic [NUM_RD-1:0] err_q, err_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [OW-1:0]     own_q, own_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;

    logic [NUM_RD:0]   req;
    logic [ADDR_W-1:0] addr_sel;
    logic              found;
    logic              host;
    logic              tmo;
    int                win;
    int                slot;

    assign req  = {bus.iHS_Start, bus.iRD_REQ};
    assign host = (state_q == S_HOST);
    assign tmo  = (TIMEOUT != 0) &&
                  (tcnt_q == TW'(TIMEOUT - 1));

    // First requesting slot at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        win   = 0;
        slot  = 0;
        for (int k = 0; k < NS; k++) begin
            slot = int'(ptr_q) + k;
            if (slot >= NS) slot = slot - NS;
            if (!found && req[IW'(slot)]) begin
                found = 1'b1;
                win   = slot;
            end
        end
    end

    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NUM_RD; i++)
            if (win == i)
                addr_sel = bus.iRD_ADDR[i*ADDR_W +: ADDR_W];
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = '0;
        err_d   = '0;
        ptr_d   = ptr_q;
        own_d   = own_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (HOST_PRIO != 0 && bus.iHS_Start) begin
                    state_d = S_HOST;
                    grant_d = '0;
                    grant_d[NUM_RD] = 1'b1;
                end else if (found) begin
                    ptr_d = (win + 1 >= NS) ? '0 : PW'(win + 1);
                    grant_d = '0;
                    grant_d[IW'(win)] = 1'b1;
                    if (win == NUM_RD) begin
                        state_d = S_HOST;
                    end else begin
                        state_d = S_ISSUE;
                        own_d   = OW'(win);
                        addr_d  = addr_sel;
                    end
                end
            end
            S_ISSUE: begin
                start_d = 1'b1;
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Ready takes precedence over a simultaneous timeout.
                if (bus.iFL_Ready || tmo) begin
                    start_d = 1'b0;
                    grant_d = '0;
                    gcnt_d  = '0;
                    state_d = S_GAP;
                    if (bus.iFL_Ready) begin
                        data_d[own_q]  = bus.iFL_DATA;
                        valid_d[own_q] = 1'b1;
                    end else begin
                        err_d[own_q] = 1'b1;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_HOST: begin
                if (!bus.iHS_Start) begin
                    grant_d = '0;
                    gcnt_d  = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gcnt_q == GW'(GAP_CYC - 1))
                    state_d = S_IDLE;
                else
                    gcnt_d = gcnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            grant_q <= '0;
            addr_q  <= '0;
            for (int i = 0; i < NUM_RD; i++)
                data_q[i] <= '0;
            valid_q <= '0;
            err_q   <= '0;
            ptr_q   <= '0;
            own_q   <= '0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    // The host sees the flash controller directly while it owns it.
    assign bus.oFL_Start = host ? bus.iHS_Start : start_q;
    assign bus.oFL_ADDR  = host ? bus.iHS_ADDR : addr_q;
    assign bus.oFL_DATA  = host ? bus.iHS_DATA : '1;
    assign bus.oFL_CMD   = host ? bus.iHS_CMD : CMD_W'(RD_CMD);
    assign bus.oHS_DATA  = host ? bus.iFL_DATA : '0;
    assign bus.oHS_Ready = host && bus.iFL_Ready;
    assign bus.oGRANT    = grant_q;
    assign bus.oRD_VALID = valid_q;
    assign bus.oRD_ERR   = err_q;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        assign bus.oRD_DATA[g*DATA_W +: DATA_W] = data_q[g];
    end
endmodule

// File: tb/tb_flash_rr_arbiter.sv
// Randomized bench for flash_rr_arbiter with a transaction-level
// round-robin model and a latency-programmable flash responder.
module tb_flash_rr_arbiter;
    localparam int NR  = 3;
    localparam int AW  = 22;
    localparam int DW  = 8;
    localparam int CW  = 3;
    localparam int GAP = 2;
    localparam int TMO = 16;

    logic iCLK = 1'b0;
    logic iRST;
    always #5 iCLK = ~iCLK;

    flash_rr_arbiter_if #(
        .NUM_RD(NR), .ADDR_W(AW), .DATA_W(DW), .CMD_W(CW)
    ) bus ();

    flash_rr_arbiter #(
        .NUM_RD(NR), .ADDR_W(AW), .DATA_W(DW), .CMD_W(CW),
        .RD_CMD(0), .HOST_PRIO(1), .GAP_CYC(GAP), .TIMEOUT(TMO)
    ) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_valid [NR];
    int n_err [NR];
    int st_cnt = 0;
    int lat = 0;
    int ptr_m = 0;
    bit fix_en = 0;
    logic [DW-1:0] fix_val = '0;
    logic [DW-1:0] fl_val = '0;
    logic [DW-1:0] ready_val = '0;
    logic [DW-1:0] exp_data [NR];
    logic [AW-1:0] addr_tab [NR];

    function automatic logic [DW-1:0] rd_out(input int i);
        return bus.oRD_DATA[i*DW +: DW];
    endfunction

    // Round-robin rule: first requester at/after the pointer wins.
    function automatic int model_next(input logic [NR-1:0] m);
        int c;
        for (int k = 0; k < NR; k++) begin
            c = (ptr_m + k) % NR;
            if (m[c]) begin
                ptr_m = (c + 1) % NR;
                return c;
            end
        end
        return -1;
    endfunction

    function automatic logic [NR:0] onehot(input int w);
        logic [NR:0] r;
        r = '0;
        r[w] = 1'b1;
        return r;
    endfunction

    task automatic set_addrs();
        for (int i = 0; i < NR; i++) begin
            addr_tab[i] = AW'($urandom);
            bus.iRD_ADDR[i*AW +: AW] = addr_tab[i];
        end
    endtask

    // Flash model: Ready in the lat-th cycle of Start being high.
    task automatic tick();
        @(negedge iCLK);
        cyc++;
        for (int i = 0; i < NR; i++) begin
            if (bus.oRD_VALID[i]) n_valid[i]++;
            if (bus.oRD_ERR[i]) n_err[i]++;
        end
        if (bus.oFL_Start) st_cnt++;
        else st_cnt = 0;
        if (st_cnt == 1)
            fl_val = fix_en ? fix_val : DW'($urandom);
        bus.iFL_Ready = (lat != 0) && (st_cnt == lat);
        bus.iFL_DATA = fl_val;
        if (bus.iFL_Ready) ready_val = fl_val;
    endtask

    task automatic wait_done(
        input int budget, output bit ok,
        output logic [NR:0] g, output logic [NR-1:0] v,
        output logic [NR-1:0] e, output int st_hi,
        output int zg
    );
        ok = 0; g = '0; v = '0; e = '0;
        st_hi = 0; zg = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            tick();
            if (bus.oFL_Start) st_hi++;
            if (bus.oGRANT != '0) g = bus.oGRANT;
            else if (g == '0) zg++;
            if (bus.oRD_VALID != '0 || bus.oRD_ERR != '0) begin
                ok = 1;
                v = bus.oRD_VALID;
                e = bus.oRD_ERR;
            end
        end
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        bus.iHS_ADDR = '0;
        bus.iHS_DATA = '0;
        bus.iHS_CMD = '0;
        bus.iHS_Start = 1'b0;
        bus.iRD_REQ = '0;
        bus.iFL_Ready = 1'b0;
        bus.iFL_DATA = '0;
        tick();
        tick();
        iRST = 1'b0;
        tick();
        ptr_m = 0;
        for (int i = 0; i < NR; i++) exp_data[i] = '0;
    endtask

    task automatic settle();
        bus.iRD_REQ = '0;
        repeat (GAP + 4) tick();
    endtask

    task automatic test_reset();
        bus.iRD_ADDR = '0;
        do_reset();
        iRST = 1'b1;
        #1;
        total++;
        if (bus.oFL_Start !== 1'b0 || bus.oGRANT !== '0) begin
            bad++;
            $display("FAIL reset_ctl: start=%0b grant=%b want 0",
                     bus.oFL_Start, bus.oGRANT);
        end
        total++;
        if (bus.oRD_VALID !== '0 || bus.oRD_ERR !== '0) begin
            bad++;
            $display("FAIL reset_pulse: valid=%b err=%b want 0",
                     bus.oRD_VALID, bus.oRD_ERR);
        end
        total++;
        if (bus.oRD_DATA !== '0 || bus.oFL_ADDR !== '0) begin
            bad++;
            $display("FAIL reset_data: data=%h addr=%h want 0",
                     bus.oRD_DATA, bus.oFL_ADDR);
        end
        total++;
        if (bus.oFL_DATA !== '1 || bus.oFL_CMD !== '0) begin
            bad++;
            $display("FAIL reset_fl: data=%h cmd=%0d want ff/0",
                     bus.oFL_DATA, bus.oFL_CMD);
        end
        total++;
        if (bus.oHS_Ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: ready=%0b want 0",
                     bus.oHS_Ready);
        end
        iRST = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        int nv, ne;
        do_reset();
        set_addrs();
        lat = 0;
        bus.iRD_REQ = 3'b010;
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            tick();
            if (bus.oFL_Start) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL midrst_start: no Start within 8 cycles");
        end
        tick();
        tick();
        nv = n_valid[1];
        ne = n_err[1];
        #2 iRST = 1'b1;
        #1;
        total++;
        if (bus.oFL_Start !== 1'b0 || bus.oGRANT !== '0) begin
            bad++;
            $display("FAIL midrst_async: start=%0b grant=%b want 0",
                     bus.oFL_Start, bus.oGRANT);
        end
        bus.iRD_REQ = '0;
        tick();
        tick();
        iRST = 1'b0;
        repeat (TMO + 10) tick();
        total++;
        if (n_valid[1] != nv || n_err[1] != ne) begin
            bad++;
            $display("FAIL midrst_pulse: valid+%0d err+%0d want 0",
                     n_valid[1] - nv, n_err[1] - ne);
        end
        total++;
        if (rd_out(1) !== '0) begin
            bad++;
            $display("FAIL midrst_data: got %h want 0", rd_out(1));
        end
        ptr_m = 0;
    endtask

    task automatic test_single_read();
        bit ok;
        logic [NR:0] g;
        logic [NR-1:0] v, e;
        int st_hi, zg, w, nv;
        fix_en = 1;
        fix_val = 8'hA5;
        lat = 7;
        addr_tab[0] = 22'h12345;
        bus.iRD_ADDR[0 +: AW] = 22'h12345;
        nv = n_valid[0];
        bus.iRD_REQ = 3'b001;
        w = model_next(3'b001);
        tick();
        total++;
        if (bus.oFL_Start !== 1'b0 || bus.oGRANT !== onehot(w)) begin
            bad++;
            $display("FAIL single_issue: start=%0b grant=%b want 0/%b",
                     bus.oFL_Start, bus.oGRANT, onehot(w));
        end
        total++;
        if (bus.oFL_ADDR !== 22'h12345 || bus.oFL_CMD !== 3'd0 ||
            bus.oFL_DATA !== 8'hFF) begin
            bad++;
            $display("FAIL single_bus: addr=%h cmd=%0d data=%h",
                     bus.oFL_ADDR, bus.oFL_CMD, bus.oFL_DATA);
        end
        bus.iRD_REQ = '0;
        tick();
        total++;
        if (bus.oFL_Start !== 1'b1) begin
            bad++;
            $display("FAIL single_t2: start=%0b want 1",
                     bus.oFL_Start);
        end
        wait_done(40, ok, g, v, e, st_hi, zg);
        total++;
        if (!ok || v !== 3'b001 || e !== '0) begin
            bad++;
            $display("FAIL single_done: ok=%0b valid=%b err=%b",
                     ok, v, e);
        end
        // The first of the 7 Start cycles was seen before the wait.
        total++;
        if (st_hi + 1 != 7) begin
            bad++;
            $display("FAIL single_starthi: got %0d want 7",
                     st_hi + 1);
        end
        exp_data[0] = 8'hA5;
        total++;
        if (rd_out(0) !== 8'hA5) begin
            bad++;
            $display("FAIL single_data: got %h want a5", rd_out(0));
        end
        repeat (GAP + 4) tick();
        total++;
        if (n_valid[0] - nv != 1) begin
            bad++;
            $display("FAIL single_pulses: got %0d want 1",
                     n_valid[0] - nv);
        end
        fix_en = 0;
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [NR:0] g;
        logic [NR-1:0] v, e, m;
        int st_hi, zg, w;
        do_reset();
        set_addrs();
        lat = 3;
        bus.iRD_REQ = 3'b111;
        for (int it = 0; it < 6; it++) begin
            w = model_next(3'b111);
            wait_done(60, ok, g, v, e, st_hi, zg);
            if (ok) exp_data[w] = ready_val;
            total++;
            if (!ok || g !== onehot(w) || v !== NR'(1 << w)) begin
                bad++;
                $display("FAIL rr_order[%0d]: grant=%b valid=%b want %0d",
                         it, g, v, w);
            end
            // GAP cycles plus one IDLE cycle; the first is the VALID cycle.
            if (it > 0) begin
                total++;
                if (zg != GAP + 1 - 1) begin
                    bad++;
                    $display("FAIL rr_gap[%0d]: got %0d want %0d",
                             it, zg, GAP);
                end
            end
        end
        for (int it = 0; it < 30; it++) begin
            m = NR'($urandom_range(1, (1 << NR) - 1));
            bus.iRD_REQ = m;
            lat = $urandom_range(1, TMO);
            w = model_next(m);
            wait_done(80, ok, g, v, e, st_hi, zg);
            if (ok) exp_data[w] = ready_val;
            total++;
            if (!ok || g !== onehot(w) || v !== NR'(1 << w) ||
                e !== '0) begin
                bad++;
                $display("FAIL rr_rand[%0d]: m=%b grant=%b valid=%b err=%b want %0d",
                         it, m, g, v, e, w);
            end
            total++;
            if (bus.oFL_ADDR !== addr_tab[w]) begin
                bad++;
                $display("FAIL rr_addr[%0d]: got %h want %h",
                         it, bus.oFL_ADDR, addr_tab[w]);
            end
            for (int i = 0; i < NR; i++) begin
                total++;
                if (rd_out(i) !== exp_data[i]) begin
                    bad++;
                    $display("FAIL rr_data[%0d][%0d]: got %h want %h",
                             it, i, rd_out(i), exp_data[i]);
                end
            end
        end
        settle();
    endtask

    task automatic test_host_priority();
        bit ok, seen, got_host, saw_v, leak, hs_ok;
        logic [NR:0] g;
        logic [NR-1:0] v, e;
        logic [DW-1:0] hv;
        int st_hi, zg, w, w2;
        lat = 6;
        bus.iRD_REQ = 3'b111;
        w = model_next(3'b111);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (bus.oFL_Start) seen = 1;
        end
        bus.iHS_ADDR = 22'h2ABCD;
        bus.iHS_DATA = 8'h3C;
        bus.iHS_CMD = 3'b001;
        bus.iHS_Start = 1'b1;
        got_host = 0;
        saw_v = 0;
        leak = 0;
        for (int k = 0; k < 60 && !got_host; k++) begin
            tick();
            #1;
            if (bus.oGRANT[NR]) begin
                got_host = 1;
            end else begin
                if (bus.oHS_Ready !== 1'b0) leak = 1;
                if (bus.oRD_VALID == NR'(1 << w)) begin
                    saw_v = 1;
                    exp_data[w] = ready_val;
                end
            end
        end
        total++;
        if (!seen || !saw_v || !got_host) begin
            bad++;
            $display("FAIL host_order: start=%0b client=%0b host=%0b want 1",
                     seen, saw_v, got_host);
        end
        total++;
        if (leak) begin
            bad++;
            $display("FAIL host_leak: oHS_Ready=1 before grant, want 0");
        end
        total++;
        if (bus.oGRANT !== onehot(NR) || bus.oFL_Start !== 1'b1) begin
            bad++;
            $display("FAIL host_grant: grant=%b start=%0b want %b/1",
                     bus.oGRANT, bus.oFL_Start, onehot(NR));
        end
        total++;
        if (bus.oFL_CMD !== 3'b001 || bus.oFL_DATA !== 8'h3C ||
            bus.oFL_ADDR !== 22'h2ABCD) begin
            bad++;
            $display("FAIL host_pass: cmd=%0d data=%h addr=%h",
                     bus.oFL_CMD, bus.oFL_DATA, bus.oFL_ADDR);
        end
        total++;
        if (rd_out(w) !== exp_data[w]) begin
            bad++;
            $display("FAIL host_client_data: got %h want %h",
                     rd_out(w), exp_data[w]);
        end
        lat = 3;
        hs_ok = 0;
        hv = '0;
        for (int k = 0; k < 10 && !hs_ok; k++) begin
            tick();
            #1;
            if (bus.oHS_Ready === 1'b1) begin
                hs_ok = 1;
                hv = bus.oHS_DATA;
            end
        end
        total++;
        if (!hs_ok || hv !== ready_val) begin
            bad++;
            $display("FAIL host_ready: ok=%0b data=%h want 1/%h",
                     hs_ok, hv, ready_val);
        end
        bus.iHS_Start = 1'b0;
        w2 = model_next(3'b111);
        wait_done(60, ok, g, v, e, st_hi, zg);
        if (ok) exp_data[w2] = ready_val;
        total++;
        if (!ok || g !== onehot(w2) || v !== NR'(1 << w2)) begin
            bad++;
            $display("FAIL host_resume: grant=%b valid=%b want %0d",
                     g, v, w2);
        end
        settle();
    endtask

    task automatic test_timeout();
        bit ok, seen;
        logic [NR:0] g;
        logic [NR-1:0] v, e;
        int st_hi, zg, w, c0;
        lat = 0;
        bus.iRD_REQ = 3'b100;
        w = model_next(3'b100);
        seen = 0;
        c0 = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (bus.oFL_Start) begin
                seen = 1;
                c0 = cyc;
            end
        end
        wait_done(40, ok, g, v, e, st_hi, zg);
        total++;
        if (!seen || !ok || e !== 3'b100 || v !== '0 ||
            g !== onehot(w)) begin
            bad++;
            $display("FAIL tmo_err: err=%b valid=%b grant=%b want 100/000",
                     e, v, g);
        end
        total++;
        if (cyc - c0 != TMO) begin
            bad++;
            $display("FAIL tmo_delay: got %0d want %0d",
                     cyc - c0, TMO);
        end
        total++;
        if (rd_out(2) !== exp_data[2]) begin
            bad++;
            $display("FAIL tmo_data: got %h want %h",
                     rd_out(2), exp_data[2]);
        end
        bus.iRD_REQ = 3'b101;
        lat = 4;
        w = model_next(3'b101);
        wait_done(60, ok, g, v, e, st_hi, zg);
        if (ok) exp_data[w] = ready_val;
        total++;
        if (!ok || v !== NR'(1 << w) || e !== '0) begin
            bad++;
            $display("FAIL tmo_next: valid=%b err=%b want client %0d",
                     v, e, w);
        end
        settle();
    endtask

    task automatic test_ready_vs_timeout();
        bit ok;
        logic [NR:0] g;
        logic [NR-1:0] v, e;
        int st_hi, zg, w;
        lat = TMO;
        bus.iRD_REQ = 3'b010;
        w = model_next(3'b010);
        wait_done(60, ok, g, v, e, st_hi, zg);
        if (ok) exp_data[w] = ready_val;
        lat = TMO + 1;
        total++;
        if (!ok || v !== 3'b010 || e !== '0) begin
            bad++;
            $display("FAIL tie_valid: valid=%b err=%b want 010/000",
                     v, e);
        end
        total++;
        if (rd_out(1) !== exp_data[1]) begin
            bad++;
            $display("FAIL tie_data: got %h want %h",
                     rd_out(1), exp_data[1]);
        end
        w = model_next(3'b010);
        wait_done(60, ok, g, v, e, st_hi, zg);
        total++;
        if (!ok || e !== 3'b010 || v !== '0) begin
            bad++;
            $display("FAIL late_err: valid=%b err=%b want 000/010",
                     v, e);
        end
        total++;
        if (rd_out(1) !== exp_data[1]) begin
            bad++;
            $display("FAIL late_data: got %h want %h",
                     rd_out(1), exp_data[1]);
        end
        settle();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            n_valid[i] = 0;
            n_err[i] = 0;
            exp_data[i] = '0;
            addr_tab[i] = '0;
        end
        test_reset();
        test_reset_mid_wait();
        test_single_read();
        test_round_robin();
        test_host_priority();
        test_timeout();
        test_ready_vs_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
